// File: rtl/fnd_pkg.sv
// fnd_pkg: 7-segment constants and nibble decoder shared by the FND scan
// controller. Codes are active-low for a common-anode panel:
// bit 7 = DP, bits 6..0 = segments g..a.
package fnd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Nibble to segment pattern; 0xA is a dash, 0xB..0xF are blank.
    // A lit DP clears bit 7 regardless of the glyph.
    function automatic logic [7:0] seg_decode(input logic [3:0] nibble, input logic dp);
        logic [7:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'hA:    seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
        if (dp) begin
            seg[7] = 1'b0;
        end
        return seg;
    endfunction

endpackage

// File: rtl/fnd_scan_timer.sv
// fnd_scan_timer: slot prescaler and digit-select counter for the FND scan.
//   clk, rst_n  : clock, asynchronous active-low reset
//   sel         : current digit slot, 0..N_DIGIT-1
//   ghost       : high during the first GHOST_CYC cycles of a slot
//   frame_wrap  : high in the last cycle of a frame (sel about to wrap to 0)
//   frame_tick  : registered one-cycle pulse in the first cycle of a frame
module fnd_scan_timer #(
    parameter int N_DIGIT   = 4,
    parameter int SLOT_CYC  = 100000,
    parameter int GHOST_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [$clog2(N_DIGIT)-1:0] sel,
    output logic                       ghost,
    output logic                       frame_wrap,
    output logic                       frame_tick
);

    localparam int CNT_W = $clog2(SLOT_CYC);
    localparam int SEL_W = $clog2(N_DIGIT);

    logic [CNT_W-1:0] cnt;
    logic             slot_wrap;

    assign slot_wrap  = (cnt == CNT_W'(SLOT_CYC - 1));
    assign frame_wrap = slot_wrap && (sel == SEL_W'(N_DIGIT - 1));
    assign ghost      = (cnt < CNT_W'(GHOST_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sel        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            if (slot_wrap) begin
                cnt <= '0;
                sel <= frame_wrap ? '0 : sel + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: multiplexed common-anode 7-segment scan driver.
//   clk, rst_n  : clock, asynchronous active-low reset
//   digits      : packed nibbles, nibble k drives digit k (digit 0 rightmost)
//   dp_mask     : per-digit decimal point enable
//   blink_mask  : per-digit blink enable
//   lz_en       : leading-zero blanking enable
//   fnd_com     : active-low digit enables (one-hot-low, all ones when dark)
//   fnd_data    : active-low segments, bit 7 = DP
//   frame_tick  : one-cycle pulse at the start of each frame
// All inputs are captured once per frame so a frame never mixes old and new data.
module fnd_scan_controller #(
    parameter int N_DIGIT      = 4,
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int GHOST_CYC    = 4,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*N_DIGIT-1:0]   digits,
    input  logic [N_DIGIT-1:0]     dp_mask,
    input  logic [N_DIGIT-1:0]     blink_mask,
    input  logic                   lz_en,
    output logic [N_DIGIT-1:0]     fnd_com,
    output logic [7:0]             fnd_data,
    output logic                   frame_tick
);

    import fnd_pkg::*;

    localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
    localparam int SEL_W    = $clog2(N_DIGIT);
    localparam int BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SEL_W-1:0]     sel;
    logic                 ghost;
    logic                 frame_wrap;

    logic [4*N_DIGIT-1:0] sh_digits;
    logic [N_DIGIT-1:0]   sh_dp;
    logic [N_DIGIT-1:0]   sh_blink;
    logic                 sh_lz;

    logic [BLK_W-1:0]     blink_cnt;
    logic                 blink_phase;

    logic [N_DIGIT-1:0]   lz_blank;
    logic                 lead;
    logic [3:0]           cur_nib;
    logic                 cur_dp;
    logic                 cur_blink;
    logic                 cur_lz;
    logic                 digit_off;

    logic [N_DIGIT-1:0]   com_p1;
    logic [7:0]           data_p1;

    fnd_scan_timer #(
        .N_DIGIT   (N_DIGIT),
        .SLOT_CYC  (SLOT_CYC),
        .GHOST_CYC (GHOST_CYC)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .ghost      (ghost),
        .frame_wrap (frame_wrap),
        .frame_tick (frame_tick)
    );

    // Frame snapshot and blink phase; both change on the same edge so a
    // whole frame sees one consistent set of display decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_blink    <= '0;
            sh_lz       <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            sh_digits <= digits;
            sh_dp     <= dp_mask;
            sh_blink  <= blink_mask;
            sh_lz     <= lz_en;
            if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Leading-zero mask: walk from the most significant digit down; the first
    // nonzero nibble or lit DP ends the run. Digit 0 always shows.
    always_comb begin
        lz_blank = '0;
        lead     = sh_lz;
        for (int k = N_DIGIT - 1; k >= 1; k--) begin
            if (lead && (sh_digits[4*k +: 4] == 4'd0) && !sh_dp[k]) begin
                lz_blank[k] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
    end

    // Per-slot selection of the shadowed digit attributes.
    always_comb begin
        cur_nib   = 4'd0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int k = 0; k < N_DIGIT; k++) begin
            if (sel == SEL_W'(k)) begin
                cur_nib   = sh_digits[4*k +: 4];
                cur_dp    = sh_dp[k];
                cur_blink = sh_blink[k];
                cur_lz    = lz_blank[k];
            end
        end
        digit_off = ghost || cur_lz || (blink_phase && cur_blink);
    end

    // Output register stage: outputs lag the slot counter by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            com_p1  <= '1;
            data_p1 <= SEG_BLANK;
        end else if (digit_off) begin
            com_p1  <= '1;
            data_p1 <= SEG_BLANK;
        end else begin
            com_p1  <= ~(N_DIGIT'(1) << sel);
            data_p1 <= seg_decode(cur_nib, cur_dp);
        end
    end

    assign fnd_com  = com_p1;
    assign fnd_data = data_p1;

endmodule
